// File: rtl/hdmi_reset_sequencer.sv
// HDMI bring-up reset sequencer: filters PLL lock, then releases TMDS reset before the game core reset.
// Optional long-press soft reset on BTN is compiled in with `define SOFT_RESET_EN.
module hdmi_reset_sequencer #(
  parameter int unsigned LOCK_FILTER    = 4,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned STAGGER_CYCLES = 8
`ifdef SOFT_RESET_EN
  , parameter int unsigned LONGPRESS_CYCLES = 25000000
`endif
) (
  input  logic       CLK_25MHZ,
  input  logic       RESET,
  input  logic       PLL_LOCKED,
  input  logic       BTN,
  output logic       RESET_TMDS,
  output logic       RESET_GAME,
  output logic       READY,
  output logic [1:0] STATE,
  output logic [7:0] LOSS_CNT
);

  localparam int unsigned FILT_W    = $clog2(LOCK_FILTER + 1);
  localparam int unsigned PHASE_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int unsigned PHASE_W   = $clog2(PHASE_MAX + 1);
  localparam int unsigned LOSS_W    = 8;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    TMDS_UP   = 2'd2,
    RUN       = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                lock_meta_q, lock_s_q;
  logic [FILT_W-1:0]   filt_q, filt_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [LOSS_W-1:0]   loss_q, loss_d;
  logic                tmds_q, tmds_d;
  logic                game_q, game_d;
  logic                ready_q, ready_d;

`ifdef SOFT_RESET_EN
  localparam int unsigned PRESS_W = $clog2(LONGPRESS_CYCLES + 1);

  logic                btn_meta_q, btn_s_q;
  logic [PRESS_W-1:0]  press_q, press_d;
  logic                press_fire_c;

  // Counter saturates, so a held button fires once and re-arms only after a low sample.
  always_comb begin
    press_d = '0;
    if (btn_s_q) begin
      press_d = (press_q == PRESS_W'(LONGPRESS_CYCLES)) ? press_q : press_q + PRESS_W'(1);
    end
  end
  assign press_fire_c = btn_s_q && (press_q == PRESS_W'(LONGPRESS_CYCLES - 1));

  always_ff @(posedge CLK_25MHZ) begin
    if (RESET) begin
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
      press_q    <= '0;
    end else begin
      btn_meta_q <= BTN;
      btn_s_q    <= btn_meta_q;
      press_q    <= press_d;
    end
  end
`else
  logic unused_btn;
  assign unused_btn = BTN;
`endif

  // Next-state, counters and output decode of the next state.
  always_comb begin
    state_d = state_q;
    loss_d  = loss_q;
    filt_d  = '0;
    if (lock_s_q) begin
      filt_d = (filt_q == FILT_W'(LOCK_FILTER)) ? filt_q : filt_q + FILT_W'(1);
    end

    case (state_q)
      WAIT_LOCK: begin
        if (filt_d == FILT_W'(LOCK_FILTER)) state_d = HOLD;
      end
      HOLD: begin
        if (!lock_s_q) state_d = WAIT_LOCK;
        else if (phase_q == PHASE_W'(HOLD_CYCLES - 1)) state_d = TMDS_UP;
      end
      TMDS_UP: begin
        if (!lock_s_q) state_d = WAIT_LOCK;
        else if (phase_q == PHASE_W'(STAGGER_CYCLES - 1)) state_d = RUN;
      end
      RUN: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          if (loss_q != {LOSS_W{1'b1}}) loss_d = loss_q + LOSS_W'(1);
        end
`ifdef SOFT_RESET_EN
        else if (press_fire_c) state_d = HOLD;
`endif
      end
      default: state_d = WAIT_LOCK;
    endcase

    phase_d = phase_q;
    if (state_d != state_q) phase_d = '0;
    else if (phase_q != PHASE_W'(PHASE_MAX)) phase_d = phase_q + PHASE_W'(1);

    tmds_d  = (state_d == WAIT_LOCK) || (state_d == HOLD);
    game_d  = (state_d != RUN);
    ready_d = (state_d == RUN);
  end

  always_ff @(posedge CLK_25MHZ) begin
    if (RESET) begin
      state_q     <= WAIT_LOCK;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      filt_q      <= '0;
      phase_q     <= '0;
      loss_q      <= '0;
      tmds_q      <= 1'b1;
      game_q      <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_meta_q <= PLL_LOCKED;
      lock_s_q    <= lock_meta_q;
      filt_q      <= filt_d;
      phase_q     <= phase_d;
      loss_q      <= loss_d;
      tmds_q      <= tmds_d;
      game_q      <= game_d;
      ready_q     <= ready_d;
    end
  end

  assign RESET_TMDS = tmds_q;
  assign RESET_GAME = game_q;
  assign READY      = ready_q;
  assign STATE      = state_q;
  assign LOSS_CNT   = loss_q;

endmodule

// File: tb/tb_hdmi_reset_sequencer.sv
// Directed bench for hdmi_reset_sequencer (default parameters; soft-reset steps only when SOFT_RESET_EN is defined).
module tb_hdmi_reset_sequencer;

  logic       clk;
  logic       rst;
  logic       pll;
  logic       btn;
  logic       rst_tmds;
  logic       rst_game;
  logic       ready;
  logic [1:0] state;
  logic [7:0] loss;

  int n_vec = 0;
  int n_err = 0;
  int loss_exp;

  hdmi_reset_sequencer #(
    .LOCK_FILTER     (4),
    .HOLD_CYCLES     (16),
    .STAGGER_CYCLES  (8)
`ifdef SOFT_RESET_EN
    , .LONGPRESS_CYCLES(10)
`endif
  ) dut (
    .CLK_25MHZ (clk),
    .RESET     (rst),
    .PLL_LOCKED(pll),
    .BTN       (btn),
    .RESET_TMDS(rst_tmds),
    .RESET_GAME(rst_game),
    .READY     (ready),
    .STATE     (state),
    .LOSS_CNT  (loss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packed {STATE, RESET_TMDS, RESET_GAME, READY}.
  task automatic chk_out(input string tag, input logic [1:0] st, input logic t, input logic g, input logic r);
    chk(tag, {27'd0, state, rst_tmds, rst_game, ready}, {27'd0, st, t, g, r});
  endtask

  initial begin
    rst = 1'b1;
    pll = 1'b1;
    btn = 1'b0;

    // Power-on reset with lock already present.
    repeat (3) tick();
    chk_out("reset_outputs", 2'd0, 1'b1, 1'b1, 1'b0);
    chk("reset_loss", {24'd0, loss}, 32'd0);
    rst = 1'b0;
    repeat (5) tick();
    chk_out("filter_edge5", 2'd0, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("hold_edge6", 2'd1, 1'b1, 1'b1, 1'b0);
    repeat (15) tick();
    chk_out("hold_edge21", 2'd1, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("tmds_up_edge22", 2'd2, 1'b0, 1'b1, 1'b0);
    repeat (7) tick();
    chk_out("tmds_up_edge29", 2'd2, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("run_edge30", 2'd3, 1'b0, 1'b0, 1'b1);

    // One-cycle lock drop in RUN, then relock.
    pll = 1'b0;
    tick();
    pll = 1'b1;
    tick();
    chk_out("run_before_sync", 2'd3, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("loss_to_wait", 2'd0, 1'b1, 1'b1, 1'b0);
    chk("loss_cnt_1", {24'd0, loss}, 32'd1);
    repeat (27) tick();
    chk_out("relock_tmds_up", 2'd2, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("relock_run", 2'd3, 1'b0, 1'b0, 1'b1);
    chk("loss_cnt_still_1", {24'd0, loss}, 32'd1);

    // Short lock pulse in WAIT_LOCK must not start the sequence.
    pll = 1'b0;
    repeat (6) tick();
    chk_out("wait_after_loss2", 2'd0, 1'b1, 1'b1, 1'b0);
    chk("loss_cnt_2", {24'd0, loss}, 32'd2);
    pll = 1'b1;
    repeat (3) tick();
    pll = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_out("glitch_stays_wait", 2'd0, 1'b1, 1'b1, 1'b0);
      tick();
    end
    pll = 1'b1;
    repeat (29) tick();
    chk_out("after_glitch_not_run", 2'd2, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("after_glitch_run", 2'd3, 1'b0, 1'b0, 1'b1);

    // Many lock losses: counter saturates at 255.
    loss_exp = 2;
    for (int k = 0; k < 256; k++) begin
      pll = 1'b0;
      repeat (3) tick();
      pll = 1'b1;
      repeat (30) tick();
      if (loss_exp < 255) loss_exp++;
      chk("loss_sat", {24'd0, loss}, 32'(loss_exp));
    end
    chk_out("run_after_losses", 2'd3, 1'b0, 1'b0, 1'b1);
    chk("loss_cnt_255", {24'd0, loss}, 32'd255);

    // RESET in the middle of TMDS_UP.
    pll = 1'b0;
    repeat (3) tick();
    chk("loss_held_255", {24'd0, loss}, 32'd255);
    pll = 1'b1;
    repeat (24) tick();
    chk_out("mid_tmds_up", 2'd2, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    chk_out("reset_mid_tmds_up", 2'd0, 1'b1, 1'b1, 1'b0);
    chk("reset_mid_tmds_up_loss", {24'd0, loss}, 32'd0);
    rst = 1'b0;
    repeat (30) tick();
    chk_out("run_after_reset", 2'd3, 1'b0, 1'b0, 1'b1);

    // RESET in RUN with a non-zero loss count.
    pll = 1'b0;
    repeat (3) tick();
    pll = 1'b1;
    repeat (30) tick();
    chk_out("run_before_reset", 2'd3, 1'b0, 1'b0, 1'b1);
    chk("loss_before_reset", {24'd0, loss}, 32'd1);
    rst = 1'b1;
    tick();
    chk_out("reset_mid_run", 2'd0, 1'b1, 1'b1, 1'b0);
    chk("reset_mid_run_loss", {24'd0, loss}, 32'd0);
    rst = 1'b0;

`ifdef SOFT_RESET_EN
    repeat (30) tick();
    chk_out("soft_pre_run", 2'd3, 1'b0, 1'b0, 1'b1);
    btn = 1'b1;
    repeat (11) tick();
    chk_out("soft_not_yet", 2'd3, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("soft_to_hold", 2'd1, 1'b1, 1'b1, 1'b0);
    chk("soft_loss_unchanged", {24'd0, loss}, 32'd0);
    repeat (24) tick();
    chk_out("soft_run_again", 2'd3, 1'b0, 1'b0, 1'b1);
    repeat (20) tick();
    chk_out("soft_held_no_retrigger", 2'd3, 1'b0, 1'b0, 1'b1);
    btn = 1'b0;
    repeat (3) tick();
    btn = 1'b1;
    repeat (11) tick();
    chk_out("soft_rearm_wait", 2'd3, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("soft_rearm_hold", 2'd1, 1'b1, 1'b1, 1'b0);
    btn = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
